// File: rtl/rmt_checkpoint_manager.sv
// rtl/rmt_checkpoint_manager.sv - circular buffer of rename-map snapshots for branch recovery
`ifndef NUM_PR
`define NUM_PR 64
`endif

module rmt_checkpoint_manager #(
  parameter int NUM_CKPT = 4,
  parameter int PR_W     = $clog2(`NUM_PR)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ext_flush,
  input  logic                          alloc_req,
  input  logic [31:0][PR_W-1:0]         alloc_snapshot,
  output logic                          alloc_ok,
  output logic [$clog2(NUM_CKPT)-1:0]   alloc_id,
  input  logic                          resolve_valid,
  input  logic [$clog2(NUM_CKPT)-1:0]   resolve_id,
  input  logic                          resolve_mispredict,
  output logic                          resolve_ready,
  output logic                          if_recall,
  output logic [31:0][PR_W-1:0]         recalled_rmt,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(NUM_CKPT):0]     count
);

  localparam int IDX_W = $clog2(NUM_CKPT);

  typedef enum logic {IDLE, RECALL} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       head_q, tail_q;
  logic [IDX_W:0]         count_q;
  logic [NUM_CKPT-1:0]    live_q, done_q;
  logic [31:0][PR_W-1:0]  snap_mem [NUM_CKPT];
  logic [31:0][PR_W-1:0]  recall_q;

  logic                   resolve_acc, mispredict, correct;
  logic                   head_free, free_eff;
  logic [IDX_W-1:0]       keep_span;

  // Age of a slot relative to the oldest live checkpoint.
  function automatic logic [IDX_W-1:0] age_of(input int slot, input logic [IDX_W-1:0] head);
    logic [IDX_W-1:0] s;
    s = IDX_W'(slot);
    return s - head;
  endfunction

  assign full          = (count_q == (IDX_W+1)'(NUM_CKPT));
  assign empty         = (count_q == '0);
  assign count         = count_q;
  assign alloc_id      = tail_q;
  assign resolve_ready = (state_q == IDLE);
  assign if_recall     = (state_q == RECALL);
  assign recalled_rmt  = recall_q;

  assign alloc_ok = alloc_req && !full && (state_q == IDLE) &&
                    !(resolve_valid && resolve_mispredict && resolve_ready) &&
                    !ext_flush && !reset;

  assign resolve_acc = resolve_valid && resolve_ready && live_q[resolve_id] && !ext_flush;
  assign mispredict  = resolve_acc && resolve_mispredict;
  assign correct     = resolve_acc && !resolve_mispredict;
  assign head_free   = live_q[head_q] && done_q[head_q];
  // A mispredict on the head itself squashes it, so it must not also be retired.
  assign free_eff    = head_free && !(mispredict && (resolve_id == head_q));
  assign keep_span   = resolve_id - head_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mispredict) state_d = RECALL;
      RECALL:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (ext_flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset || ext_flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      live_q  <= '0;
      done_q  <= '0;
    end else begin
      if (alloc_ok) begin
        live_q[tail_q] <= 1'b1;
        done_q[tail_q] <= 1'b0;
        tail_q         <= tail_q + 1'b1;
      end
      if (correct) done_q[resolve_id] <= 1'b1;
      if (free_eff) begin
        live_q[head_q] <= 1'b0;
        done_q[head_q] <= 1'b0;
        head_q         <= head_q + 1'b1;
      end
      if (mispredict) begin
        tail_q <= resolve_id;
        for (int i = 0; i < NUM_CKPT; i++) begin
          if (age_of(i, head_q) >= keep_span) begin
            live_q[i] <= 1'b0;
            done_q[i] <= 1'b0;
          end
        end
        count_q <= {1'b0, keep_span} - (IDX_W+1)'(free_eff);
      end else begin
        count_q <= count_q + (IDX_W+1)'(alloc_ok) - (IDX_W+1)'(free_eff);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_ok)   snap_mem[tail_q] <= alloc_snapshot;
    if (mispredict) recall_q <= snap_mem[resolve_id];
  end

endmodule

// File: tb/tb_rmt_checkpoint_manager.sv
// tb/tb_rmt_checkpoint_manager.sv - scoreboard bench for rmt_checkpoint_manager
module tb_rmt_checkpoint_manager;

  localparam int PR_W = 6;
  localparam int NUM_CKPT = 4;

  logic                  clk = 1'b0;
  logic                  reset, ext_flush, alloc_req;
  logic [31:0][PR_W-1:0] alloc_snapshot;
  logic                  alloc_ok;
  logic [1:0]            alloc_id;
  logic                  resolve_valid, resolve_mispredict;
  logic [1:0]            resolve_id;
  logic                  resolve_ready, if_recall;
  logic [31:0][PR_W-1:0] recalled_rmt;
  logic                  full, empty;
  logic [2:0]            count;

  int checks = 0;
  int errors = 0;
  logic [1:0]            exp_id_q [$];
  logic [31:0][PR_W-1:0] exp_rmt_q [$];

  always #5 clk = ~clk;

  rmt_checkpoint_manager #(.NUM_CKPT(NUM_CKPT), .PR_W(PR_W)) dut (
    .clk(clk), .reset(reset), .ext_flush(ext_flush),
    .alloc_req(alloc_req), .alloc_snapshot(alloc_snapshot),
    .alloc_ok(alloc_ok), .alloc_id(alloc_id),
    .resolve_valid(resolve_valid), .resolve_id(resolve_id),
    .resolve_mispredict(resolve_mispredict), .resolve_ready(resolve_ready),
    .if_recall(if_recall), .recalled_rmt(recalled_rmt),
    .full(full), .empty(empty), .count(count)
  );

  function automatic logic [31:0][PR_W-1:0] snap(input int k);
    logic [31:0][PR_W-1:0] s;
    for (int j = 0; j < 32; j++) s[j] = PR_W'(k * 7 + j * 3 + 1);
    return s;
  endfunction

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: grant checked mid-cycle, recall scoreboard checked just after the edge.
  task automatic cyc(input logic exp_grant);
    #3;
    check("alloc_ok", alloc_ok, exp_grant);
    if (alloc_ok) begin
      if (exp_id_q.size() == 0) check("alloc_unexpected", 1, 0);
      else check("alloc_id", alloc_id, exp_id_q.pop_front());
    end
    @(posedge clk); #1;
    if (if_recall) begin
      if (exp_rmt_q.size() == 0) check("recall_unexpected", 1, 0);
      else check("recalled_rmt", recalled_rmt, exp_rmt_q.pop_front());
    end
  endtask

  task automatic do_alloc(input int k, input logic [1:0] id);
    alloc_req = 1'b1;
    alloc_snapshot = snap(k);
    exp_id_q.push_back(id);
    cyc(1'b1);
    alloc_req = 1'b0;
  endtask

  task automatic do_resolve(input logic [1:0] id, input logic mis);
    resolve_valid = 1'b1;
    resolve_id = id;
    resolve_mispredict = mis;
    cyc(1'b0);
    resolve_valid = 1'b0;
    resolve_mispredict = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ext_flush = 1'b0; alloc_req = 1'b1; alloc_snapshot = snap(77);
    resolve_valid = 1'b0; resolve_id = '0; resolve_mispredict = 1'b0;
    @(posedge clk); #1;
    cyc(1'b0);
    cyc(1'b0);
    reset = 1'b0; alloc_req = 1'b0;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_if_recall", if_recall, 0);
    check("rst_ready", resolve_ready, 1);

    for (int k = 0; k < 4; k++) do_alloc(k, 2'(k));
    check("fill_full", full, 1);
    check("fill_count", count, 4);
    alloc_req = 1'b1; alloc_snapshot = snap(99);
    cyc(1'b0);
    alloc_req = 1'b0;
    check("full_hold_count", count, 4);

    exp_rmt_q.push_back(snap(1));
    do_resolve(2'd1, 1'b1);
    check("mis_count", count, 1);
    check("mis_ready", resolve_ready, 0);
    check("mis_recall", if_recall, 1);
    alloc_req = 1'b1; alloc_snapshot = snap(50);
    cyc(1'b0);
    alloc_req = 1'b0;
    check("post_recall_idle", if_recall, 0);
    check("post_recall_ready", resolve_ready, 1);

    for (int k = 4; k < 7; k++) do_alloc(k, 2'(k - 3));
    check("refill_full", full, 1);

    do_resolve(2'd1, 1'b0);
    check("free_none_after_id1", count, 4);
    do_resolve(2'd0, 1'b0);
    check("free_none_yet", count, 4);
    cyc(1'b0);
    check("free_head0", count, 3);
    cyc(1'b0);
    check("free_head1", count, 2);

    do_resolve(2'd2, 1'b0);
    check("done2_count", count, 2);
    do_alloc(7, 2'd0);
    check("grant_and_free", count, 2);
    do_alloc(8, 2'd1);
    check("wrap_count3", count, 3);
    exp_rmt_q.push_back(snap(7));
    do_resolve(2'd0, 1'b1);
    check("wrap_mis_count", count, 1);
    cyc(1'b0);
    do_alloc(9, 2'd0);
    check("wrap_tail0", count, 2);

    alloc_req = 1'b1; alloc_snapshot = snap(10);
    exp_rmt_q.push_back(snap(9));
    do_resolve(2'd0, 1'b1);
    alloc_req = 1'b0;
    check("collide_count", count, 1);
    ext_flush = 1'b1;
    cyc(1'b0);
    ext_flush = 1'b0;
    check("flush_recall", if_recall, 0);
    check("flush_empty", empty, 1);
    check("flush_count", count, 0);

    do_alloc(11, 2'd0);
    ext_flush = 1'b1;
    do_resolve(2'd0, 1'b1);
    ext_flush = 1'b0;
    check("flush_mis_recall", if_recall, 0);
    check("flush_mis_empty", empty, 1);

    do_alloc(12, 2'd0);
    exp_rmt_q.push_back(snap(12));
    do_resolve(2'd0, 1'b1);
    check("pre_reset_recall", if_recall, 1);
    reset = 1'b1;
    cyc(1'b0);
    reset = 1'b0;
    check("rst_mid_recall", if_recall, 0);
    check("rst_mid_count", count, 0);
    check("rst_mid_ready", resolve_ready, 1);

    check("id_queue_drained", exp_id_q.size(), 0);
    check("rmt_queue_drained", exp_rmt_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
